// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered RV32I ALU decoder with valid/ready on both sides,
// multi-cycle MUL hold, illegal-encoding flag and saturating illegal counter.
module decode_issue_stage #(
  parameter int XLEN        = 32,
  parameter int SUPPORT_M   = 1,
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  output logic             alu_src_imm,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_FULL} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [3:0]      d_alu;
  logic            d_ill;
  logic            d_src;
  logic            d_mul;
  logic [XLEN-1:0] d_imm;
  logic            capture;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign in_ready = (state == S_EMPTY) || ((state == S_FULL) && out_ready);
  assign capture  = in_valid && in_ready;

  // Base operation selected by funct3 alone (funct7 = 0 form)
  function automatic logic [3:0] f3_op(input logic [2:0] f);
    case (f)
      3'd0:    f3_op = ALU_ADD;
      3'd1:    f3_op = ALU_SLL;
      3'd2:    f3_op = ALU_SLT;
      3'd3:    f3_op = ALU_SLTU;
      3'd4:    f3_op = ALU_XOR;
      3'd5:    f3_op = ALU_SRL;
      3'd6:    f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  // Combinational decode of the incoming word; illegal encodings keep the zero defaults
  always_comb begin
    d_alu = '0;
    d_ill = 1'b1;
    d_src = 1'b0;
    d_mul = 1'b0;
    d_imm = '0;
    if (opcode == OP_R) begin
      if (f7 == 7'h00) begin
        d_alu = f3_op(f3);
        d_ill = 1'b0;
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        d_alu = ALU_SUB;
        d_ill = 1'b0;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        d_alu = ALU_SRA;
        d_ill = 1'b0;
      end else if (SUPPORT_M != 0 && f7 == 7'h01 && f3 == 3'd0) begin
        d_alu = ALU_MUL;
        d_mul = 1'b1;
        d_ill = 1'b0;
      end
    end else if (opcode == OP_I) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00) begin
          d_alu = f3_op(f3);
          d_ill = 1'b0;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          d_alu = ALU_SRA;
          d_ill = 1'b0;
        end
        if (!d_ill) begin
          d_src = 1'b1;
          d_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
      end else begin
        d_alu = f3_op(f3);
        d_ill = 1'b0;
        d_src = 1'b1;
        d_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
    end
  end

  // Handshake FSM, MUL latency counter, output register and illegal counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_EMPTY;
      cnt           <= '0;
      out_valid     <= 1'b0;
      alu_control   <= '0;
      regwrite      <= 1'b0;
      alu_src_imm   <= 1'b0;
      imm           <= '0;
      rd            <= '0;
      rs1           <= '0;
      rs2           <= '0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      alu_control <= d_alu;
      regwrite    <= ~d_ill;
      alu_src_imm <= d_src;
      imm         <= d_imm;
      rd          <= instr[11:7];
      rs1         <= instr[19:15];
      rs2         <= instr[24:20];
      illegal     <= d_ill;
      if (d_ill && illegal_count != '1)
        illegal_count <= illegal_count + CNT_W'(1);
      if (d_mul && MUL_LATENCY > 1) begin
        state     <= S_WAIT;
        cnt       <= CW'(MUL_LATENCY - 1);
        out_valid <= 1'b0;
      end else begin
        state     <= S_FULL;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state     <= S_FULL;
            out_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage.
module tb_decode_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        regwrite;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic        illegal;
  logic [1:0]  illegal_count;

  logic        nm_in_valid;
  logic        nm_in_ready;
  logic        nm_out_valid;
  logic        nm_out_ready;
  logic [3:0]  nm_alu_control;
  logic        nm_regwrite;
  logic        nm_alu_src_imm;
  logic [31:0] nm_imm;
  logic [4:0]  nm_rd, nm_rs1, nm_rs2;
  logic        nm_illegal;
  logic [15:0] nm_illegal_count;

  int checks;
  int failures;

  decode_issue_stage #(.XLEN(32), .SUPPORT_M(1), .MUL_LATENCY(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .regwrite(regwrite), .alu_src_imm(alu_src_imm), .imm(imm), .rd(rd), .rs1(rs1),
    .rs2(rs2), .illegal(illegal), .illegal_count(illegal_count)
  );

  decode_issue_stage #(.XLEN(32), .SUPPORT_M(0), .MUL_LATENCY(3), .CNT_W(16)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .instr(instr), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .alu_control(nm_alu_control), .regwrite(nm_regwrite), .alu_src_imm(nm_alu_src_imm),
    .imm(nm_imm), .rd(nm_rd), .rs1(nm_rs1), .rs2(nm_rs2), .illegal(nm_illegal),
    .illegal_count(nm_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    #1;
    check("issue_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] tbl_instr [8];
  logic [3:0]  tbl_alu   [8];
  logic [31:0] tbl_imm   [8];

  initial begin
    int sent, recv;
    logic stalled;
    logic [4:0] hold_rd;
    logic [3:0] hold_alu;

    checks = 0; failures = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    nm_in_valid = 1'b0; nm_out_ready = 1'b0;

    tbl_instr[0] = 32'h402081B3; tbl_alu[0] = 4'b0100; tbl_imm[0] = 32'h0;        // SUB
    tbl_instr[1] = 32'h002091B3; tbl_alu[1] = 4'b0011; tbl_imm[1] = 32'h0;        // SLL
    tbl_instr[2] = 32'h0020C1B3; tbl_alu[2] = 4'b0111; tbl_imm[2] = 32'h0;        // XOR
    tbl_instr[3] = 32'h0020B1B3; tbl_alu[3] = 4'b1010; tbl_imm[3] = 32'h0;        // SLTU
    tbl_instr[4] = 32'h0020F1B3; tbl_alu[4] = 4'b0000; tbl_imm[4] = 32'h0;        // AND
    tbl_instr[5] = 32'h4020D1B3; tbl_alu[5] = 4'b1001; tbl_imm[5] = 32'h0;        // SRA
    tbl_instr[6] = 32'h0050A193; tbl_alu[6] = 4'b1000; tbl_imm[6] = 32'h5;        // SLTI 5
    tbl_instr[7] = 32'hFFF0E193; tbl_alu[7] = 4'b0001; tbl_imm[7] = 32'hFFFFFFFF; // ORI -1

    // Reset state
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu", alu_control, 0);
    check("rst_imm", imm, 0);
    check("rst_cnt", illegal_count, 0);
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2 : visible the cycle after capture
    issue(32'h002081B3);
    check("add_valid", out_valid, 1);
    check("add_alu", alu_control, 4'b0010);
    check("add_rw", regwrite, 1);
    check("add_src", alu_src_imm, 0);
    check("add_rd", rd, 3);
    check("add_rs1", rs1, 1);
    check("add_rs2", rs2, 2);
    check("add_ill", illegal, 0);
    out_ready = 1'b1;
    step();
    check("add_drain", out_valid, 0);

    // ADDI x5,x0,-1 then SRAI x5,x5,4 back-to-back
    issue(32'hFFF00293);
    check("addi_alu", alu_control, 4'b0010);
    check("addi_src", alu_src_imm, 1);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_rd", rd, 5);
    check("addi_rs1", rs1, 0);
    issue(32'h4042D293);
    check("srai_valid", out_valid, 1);
    check("srai_alu", alu_control, 4'b1001);
    check("srai_imm", imm, 32'h4);
    check("srai_rs1", rs1, 5);

    // Remaining R/I encodings, one per cycle
    for (int i = 0; i < 8; i++) begin
      issue(tbl_instr[i]);
      check("tbl_alu", alu_control, tbl_alu[i]);
      check("tbl_imm", imm, tbl_imm[i]);
      check("tbl_rw", regwrite, 1);
    end
    step();
    check("tbl_drain", out_valid, 0);

    // MUL x1,x2,x3 : 3-cycle latency; illegal in the SUPPORT_M=0 instance
    nm_in_valid = 1'b1;
    issue(32'h023100B3);
    nm_in_valid = 1'b0;
    check("mul_c1_valid", out_valid, 0);
    check("mul_c1_ready", in_ready, 0);
    check("nm_valid", nm_out_valid, 1);
    check("nm_ill", nm_illegal, 1);
    check("nm_rw", nm_regwrite, 0);
    check("nm_alu", nm_alu_control, 0);
    check("nm_rd", nm_rd, 1);
    check("nm_cnt", nm_illegal_count, 1);
    step();
    check("mul_c2_valid", out_valid, 0);
    check("mul_c2_ready", in_ready, 0);
    step();
    check("mul_c3_valid", out_valid, 1);
    check("mul_alu", alu_control, 4'b0110);
    check("mul_ready_full", in_ready, 1);
    nm_out_ready = 1'b1;
    step();
    check("mul_drain", out_valid, 0);
    check("nm_drain", nm_out_valid, 0);

    // Stream of four ADDs, out_ready pattern 1,0,1,1
    sent = 0; recv = 0; stalled = 1'b0; hold_rd = '0; hold_alu = '0;
    for (int k = 0; k < 20 && recv < 4; k++) begin
      out_ready = (k == 1) ? 1'b0 : 1'b1;
      in_valid  = (sent < 4);
      instr     = 32'h00208033 | (32'(sent + 1) << 7);
      #1;
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_rd", rd, hold_rd);
        check("stall_alu", alu_control, hold_alu);
      end
      if (out_valid && out_ready) begin
        check("stream_rd", rd, 5'(recv + 1));
        recv++;
      end
      stalled  = out_valid && !out_ready;
      hold_rd  = rd;
      hold_alu = alu_control;
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    check("stream_count", recv, 4);

    // Illegal encodings and counter saturation (2-bit counter)
    out_ready = 1'b1;
    issue(32'h0000037F);
    check("ill1_flag", illegal, 1);
    check("ill1_rw", regwrite, 0);
    check("ill1_alu", alu_control, 0);
    check("ill1_imm", imm, 0);
    check("ill1_rd", rd, 6);
    check("ill1_cnt", illegal_count, 1);
    issue(32'h200001B3);
    check("ill2_flag", illegal, 1);
    check("ill2_rw", regwrite, 0);
    check("ill2_cnt", illegal_count, 2);
    issue(32'h0000007F);
    check("ill3_cnt", illegal_count, 3);
    issue(32'h40001093);
    check("bad_slli", illegal, 1);
    check("sat_cnt", illegal_count, 3);
    step();

    // Flush during WAIT drops the MUL
    issue(32'h023100B3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_cnt", illegal_count, 3);
    for (int k = 0; k < 4; k++) begin
      step();
      check("flush_quiet", out_valid, 0);
    end

    // Async reset during WAIT drops the MUL
    issue(32'h023100B3);
    step();
    rst_n = 1'b0;
    #2;
    check("rstw_valid", out_valid, 0);
    check("rstw_ready", in_ready, 1);
    check("rstw_cnt", illegal_count, 0);
    check("rstw_alu", alu_control, 0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rstw_quiet", out_valid, 0);
    end
    check("rstw_ready2", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
